temp_sensor_if: RTL and testbench

Serial front end for the incubator temperature loop, feeding `digital_control`. It periodically reads a 16-bit frame from an external 3-wire temperature sensor, converts it to whole degrees Celsius, and clamps the result to the controller's working range. It presents the value as the signed 8-bit `T` bus that `digital_control` consumes. It holds the last good reading between conversions and flags a disconnected sensor.

---
 rtl/temp_sensor_if.sv | 198 +++++++++++++++++++
 tb/tb_temp_sensor_if.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_if.sv
// Serial temperature sensor front end: periodic 16-bit frame read, conversion to clamped whole degrees C.
// Optional TEMP_AVG_EN: output is the floor average of the last four valid clamped samples.
`timescale 1ns/1ps
module temp_sensor_if #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int T_MIN         = -10,
    parameter int T_MAX         = 60
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              sdi,
    output logic              sclk,
    output logic              csN,
    output logic signed [7:0] T,
    output logic              T_valid,
    output logic              sensorErr,
    output logic              busy
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [DW-1:0]       DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0]       PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic signed [7:0]   TMIN8    = 8'(T_MIN);
    localparam logic signed [7:0]   TMAX8    = 8'(T_MAX);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE} state_t;

    state_t              state, state_nx;
    logic [DW-1:0]       div_cnt, div_nx;
    logic                phase_hi, phase_nx;
    logic [3:0]          bit_cnt, bit_nx;
    logic [PW-1:0]       per_cnt;
    logic                pending, wrap, take, div_last;
    logic                shift_en, load_en;
    logic [15:0]         sreg;
    logic signed [7:0]   clamp_p0, t_out;

    // Frame upper 12 bits are 1/16 degC; floor to whole degrees then saturate to the working range.
    function automatic logic signed [7:0] sat_deg(input logic [11:0] d);
        logic signed [11:0] raw;
        logic signed [7:0]  deg;
        raw = d;
        deg = 8'(raw >>> 4);
        if (deg < TMIN8)
            sat_deg = TMIN8;
        else if (deg > TMAX8)
            sat_deg = TMAX8;
        else
            sat_deg = deg;
    endfunction

    assign wrap     = (per_cnt == PER_LAST);
    assign div_last = (div_cnt == DIV_LAST);
    assign sclk     = (state == SHIFT) && phase_hi;
    assign csN      = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            div_cnt  <= '0;
            phase_hi <= 1'b0;
            bit_cnt  <= '0;
            pending  <= 1'b0;
            per_cnt  <= '0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            phase_hi <= phase_nx;
            bit_cnt  <= bit_nx;
            pending  <= (pending | wrap) & ~take;
            per_cnt  <= wrap ? '0 : per_cnt + PW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        phase_nx = phase_hi;
        bit_nx   = bit_cnt;
        take     = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        case (state)
            IDLE: begin
                if (pending || wrap) begin
                    take     = 1'b1;
                    state_nx = SETUP;
                    div_nx   = '0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_nx = SHIFT;
                    div_nx   = '0;
                    phase_nx = 1'b0;
                    bit_nx   = '0;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_nx = '0;
                    if (!phase_hi) begin
                        // sdi is captured on the edge that raises sclk
                        phase_nx = 1'b1;
                        shift_en = 1'b1;
                    end else begin
                        phase_nx = 1'b0;
                        if (bit_cnt == 4'd15)
                            state_nx = HOLD;
                        else
                            bit_nx = bit_cnt + 4'd1;
                    end
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_nx = UPDATE;
                    load_en  = 1'b1;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en)
            sreg <= {sreg[14:0], sdi};
    end

    assign clamp_p0 = sat_deg(sreg[15:4]);

`ifdef TEMP_AVG_EN
    // Three stored samples plus the incoming one form the four-sample window.
    logic signed [7:0] hist [3];
    logic              primed;
    logic signed [9:0] sum_p0;

    always_comb begin
        if (primed)
            sum_p0 = 10'(clamp_p0) + 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]);
        else
            sum_p0 = 10'(clamp_p0) <<< 2;
        t_out = 8'(sum_p0 >>> 2);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            primed <= 1'b0;
        else if (load_en && (sreg != 16'hFFFF))
            primed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (load_en && (sreg != 16'hFFFF)) begin
            if (primed) begin
                hist[2] <= hist[1];
                hist[1] <= hist[0];
                hist[0] <= clamp_p0;
            end else begin
                hist[2] <= clamp_p0;
                hist[1] <= clamp_p0;
                hist[0] <= clamp_p0;
            end
        end
    end
`else
    assign t_out = clamp_p0;
`endif

    // Update stage: result registers change on the edge that enters UPDATE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            T         <= '0;
            T_valid   <= 1'b0;
            sensorErr <= 1'b0;
        end else if (load_en) begin
            if (sreg == 16'hFFFF) begin
                sensorErr <= 1'b1;
                T_valid   <= 1'b0;
            end else begin
                sensorErr <= 1'b0;
                T_valid   <= 1'b1;
                T         <= t_out;
            end
        end else begin
            T_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_temp_sensor_if.sv
// Directed bench for temp_sensor_if: sensor model drives frames, a reference model fills the scoreboard.
`timescale 1ns/1ps
module tb_temp_sensor_if;
    localparam int CD = 4;
    localparam int SP = 1000;
`ifdef TEMP_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] t;
        logic       err;
        logic       vld;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic sdi = 1'b0;
    logic sclk_a, csN_a, T_valid_a, sensorErr_a, busy_a;
    logic sclk_b, csN_b, T_valid_b, sensorErr_b, busy_b;
    logic signed [7:0] T_a, T_b;

    logic [15:0] cur_frame = 16'h0000;
    int   cyc;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   hist[2][4];
    bit   primed[2];
    logic [7:0] prev[2];

    always #5 clk = ~clk;

    temp_sensor_if #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .T_MIN(-10), .T_MAX(60)) dut_a (
        .clk(clk), .rstN(rstN), .sdi(sdi), .sclk(sclk_a), .csN(csN_a), .T(T_a),
        .T_valid(T_valid_a), .sensorErr(sensorErr_a), .busy(busy_a)
    );

    temp_sensor_if #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .T_MIN(-128), .T_MAX(60)) dut_b (
        .clk(clk), .rstN(rstN), .sdi(sdi), .sclk(sclk_b), .csN(csN_b), .T(T_b),
        .T_valid(T_valid_b), .sensorErr(sensorErr_b), .busy(busy_b)
    );

    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Sensor: present MSB at chip-select fall, next bit after each sclk fall.
    initial begin
        forever begin
            int idx;
            @(negedge csN_a);
            idx = 0;
            sdi = cur_frame[15];
            while (!csN_a && idx < 16) begin
                @(negedge sclk_a or posedge csN_a);
                idx++;
                if (idx < 16) sdi = cur_frame[15 - idx];
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            prev[k]   = 8'h00;
            primed[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [15:0] f, input int tmin);
        exp_t e;
        int v, deg, s, o;
        if (f == 16'hFFFF) begin
            e.t = prev[k]; e.err = 1'b1; e.vld = 1'b0;
        end else begin
            v   = int'($signed(f[15:4]));
            deg = (v >= 0) ? v / 16 : -((-v + 15) / 16);
            if (deg < tmin) deg = tmin;
            if (deg > 60)   deg = 60;
            if (AVG) begin
                if (!primed[k]) begin
                    for (int j = 0; j < 4; j++) hist[k][j] = deg;
                end else begin
                    for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
                    hist[k][0] = deg;
                end
                primed[k] = 1'b1;
                s = hist[k][0] + hist[k][1] + hist[k][2] + hist[k][3];
                o = (s >= 0) ? s / 4 : -((-s + 3) / 4);
            end else begin
                o = deg;
            end
            e.t = 8'(o); e.err = 1'b0; e.vld = 1'b1;
            prev[k] = e.t;
        end
        if (k == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic do_frame(input logic [15:0] f, input bit chk_start);
        exp_t ea, eb;
        logic found;
        cur_frame = f;
        model_step(0, f, -10);
        model_step(1, f, -128);
        found = 1'b0;
        for (int i = 0; i < 2 * SP + 10; i++) begin
            @(negedge clk);
            if (!csN_a) begin found = 1'b1; break; end
        end
        chk("csn_fall_seen", {15'h0, found}, 16'h1);
        if (chk_start) chk("csn_fall_cycle", 16'(cyc), 16'(SP));
        repeat (CD * 34) @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("tvalid_a", {15'h0, T_valid_a}, {15'h0, ea.vld});
        chk("t_a", {8'h0, T_a}, {8'h0, ea.t});
        chk("err_a", {15'h0, sensorErr_a}, {15'h0, ea.err});
        chk("tvalid_b", {15'h0, T_valid_b}, {15'h0, eb.vld});
        chk("t_b", {8'h0, T_b}, {8'h0, eb.t});
        chk("err_b", {15'h0, sensorErr_b}, {15'h0, eb.err});
        chk("csn_high_update", {15'h0, csN_a}, 16'h1);
        chk("busy_update", {15'h0, busy_a}, 16'h1);
        @(negedge clk);
        chk("tvalid_drop", {15'h0, T_valid_a}, 16'h0);
        chk("t_hold", {8'h0, T_a}, {8'h0, ea.t});
        chk("busy_end", {15'h0, busy_a}, 16'h0);
    endtask

    initial begin
        logic found;
        logic prev_s;
        int   nhi;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_t", {8'h0, T_a}, 16'h0);
        chk("rst_tvalid", {15'h0, T_valid_a}, 16'h0);
        chk("rst_err", {15'h0, sensorErr_a}, 16'h0);
        chk("rst_busy", {15'h0, busy_a}, 16'h0);
        chk("rst_sclk", {15'h0, sclk_a}, 16'h0);
        chk("rst_csn", {15'h0, csN_a}, 16'h1);
        rstN = 1'b1;

        do_frame(16'h1900, 1'b1);
        do_frame(16'hF600, 1'b0);
        do_frame(16'hFF80, 1'b0);
        do_frame(16'h4B00, 1'b0);
        do_frame(16'hE000, 1'b0);
        do_frame(16'h1900, 1'b0);
        do_frame(16'hFFFF, 1'b0);
        do_frame(16'h1A00, 1'b0);

        // Abort a frame during the 8th sclk high phase.
        cur_frame = 16'h1900;
        found = 1'b0;
        for (int i = 0; i < 2 * SP + 10; i++) begin
            @(negedge clk);
            if (!csN_a) begin found = 1'b1; break; end
        end
        chk("abort_csn_fall", {15'h0, found}, 16'h1);
        prev_s = 1'b0;
        nhi = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sclk_a && !prev_s) nhi++;
            prev_s = sclk_a;
            if (nhi == 8) break;
        end
        chk("abort_sclk_phase", 16'(nhi), 16'd8);
        #1 rstN = 1'b0;
        #1;
        chk("abort_csn", {15'h0, csN_a}, 16'h1);
        chk("abort_sclk", {15'h0, sclk_a}, 16'h0);
        chk("abort_t", {8'h0, T_a}, 16'h0);
        chk("abort_busy", {15'h0, busy_a}, 16'h0);
        chk("abort_csn_b", {15'h0, csN_b}, 16'h1);
        repeat (2) @(negedge clk);
        model_reset();
        rstN = 1'b1;

        do_frame(16'h1400, 1'b1);
        do_frame(16'h1400, 1'b0);
        do_frame(16'h1400, 1'b0);
        do_frame(16'h1700, 1'b0);
        do_frame(16'h1700, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
